// File: rtl/ctrl_seq_pkg.sv
// ctrl_seq_pkg
// Purpose: shared types and constants for the ctrl_seq control sequencer:
//   non-ALU opcode values, the FSM state enum, the instruction-word field
//   layout and a helper that classifies ALU opcodes.
// Ports: none (package).
package ctrl_seq_pkg;

    localparam logic [3:0] OP_JMP = 4'd11;
    localparam logic [3:0] OP_SKC = 4'd12;
    localparam logic [3:0] OP_SKZ = 4'd13;
    localparam logic [3:0] OP_NOP = 4'd14;
    localparam logic [3:0] OP_HLT = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_WB,
        ST_HALT
    } state_t;

    // Instruction word layout: [15:12] op, [11:8] hi, [7:0] lit.
    typedef struct packed {
        logic [3:0] op;
        logic [3:0] hi;
        logic [7:0] lit;
    } instr_t;

    // Opcodes 0..last are forwarded to the ALU.
    function automatic logic is_alu_op(input logic [3:0] op, input int last);
        return int'(op) <= last;
    endfunction

endpackage

// File: rtl/ctrl_seq_decode.sv
// ctrl_seq_decode
// Purpose: combinational instruction decode for ctrl_seq.
// Ports:
//   ir          in   instr_t   latched instruction word
//   is_alu      out  1         opcode is forwarded to the ALU
//   is_jmp      out  1         JMP
//   is_skc      out  1         skip-if-carry
//   is_skz      out  1         skip-if-zero
//   is_hlt      out  1         halt
//   jmp_target  out  PC_W      {hi,lit} zero-extended to PC_W
// Anything not flagged here is a NOP.
module ctrl_seq_decode
    import ctrl_seq_pkg::*;
#(
    parameter int PC_W        = 17,
    parameter int LAST_ALU_OP = 10
) (
    input  instr_t          ir,
    output logic            is_alu,
    output logic            is_jmp,
    output logic            is_skc,
    output logic            is_skz,
    output logic            is_hlt,
    output logic [PC_W-1:0] jmp_target
);

    always_comb begin
        is_alu     = is_alu_op(ir.op, LAST_ALU_OP);
        is_jmp     = !is_alu && (ir.op == OP_JMP);
        is_skc     = !is_alu && (ir.op == OP_SKC);
        is_skz     = !is_alu && (ir.op == OP_SKZ);
        is_hlt     = !is_alu && (ir.op == OP_HLT);
        jmp_target = PC_W'({ir.hi, ir.lit});
    end

endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq
// Purpose: multi-cycle control sequencer for the 8-bit W-register/ALU
//   datapath. Fetches 16-bit words over a req/valid handshake, drives the
//   ALU opcode/operand, strobes W write-back, keeps carry/zero flags and
//   executes JMP / SKC / SKZ / NOP / HLT.
// Ports:
//   clk         in   1     clock, rising edge
//   reset       in   1     asynchronous active-low reset
//   run         in   1     keep fetching while high (sampled between instructions)
//   pc          out  PC_W  current instruction address
//   imem_req    out  1     fetch request (high exactly while in FETCH)
//   imem_valid  in   1     fetch data valid
//   imem_data   in   16    instruction word
//   alu_inst    out  4     ALU opcode (EXEC/WB of ALU ops only)
//   alu_b       out  8     ALU b operand
//   alu_ans     in   9     ALU result, bit 8 = carry
//   w_we        out  1     W-register write strobe (WB)
//   c_flag      out  1     carry flag
//   z_flag      out  1     zero flag
//   busy        out  1     FETCH/EXEC/WB
//   halted      out  1     HALT
//   imem_err    out  1     fetch timeout, sticky (only with CTRL_SEQ_TIMEOUT_EN)
// Build option: define CTRL_SEQ_TIMEOUT_EN to bound the FETCH wait to
//   TIMEOUT cycles; on expiry the sequencer halts and raises imem_err.
module ctrl_seq
    import ctrl_seq_pkg::*;
#(
    parameter int              PC_W        = 17,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter int              LAST_ALU_OP = 10
`ifdef CTRL_SEQ_TIMEOUT_EN
    ,
    parameter int              TIMEOUT     = 15
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    output logic [PC_W-1:0] pc,
    output logic            imem_req,
    input  logic            imem_valid,
    input  logic [15:0]     imem_data,
    output logic [3:0]      alu_inst,
    output logic [7:0]      alu_b,
    input  logic [8:0]      alu_ans,
    output logic            w_we,
    output logic            c_flag,
    output logic            z_flag,
`ifdef CTRL_SEQ_TIMEOUT_EN
    output logic            imem_err,
`endif
    output logic            busy,
    output logic            halted
);

    state_t          state_reg;
    state_t          state_next;
    instr_t          ir_reg;
    instr_t          fetch_word;
    logic [8:0]      ans_q;
    logic [PC_W-1:0] pc_plus1;
    logic [PC_W-1:0] pc_plus2;

    logic            is_alu;
    logic            is_jmp;
    logic            is_skc;
    logic            is_skz;
    logic            is_hlt;
    logic [PC_W-1:0] jmp_target;

`ifdef CTRL_SEQ_TIMEOUT_EN
    logic [3:0]      wait_cnt_reg;
    logic            fetch_timeout;
    assign fetch_timeout = (state_reg == ST_FETCH) && !imem_valid
                           && (wait_cnt_reg == 4'(TIMEOUT - 1));
`endif

    ctrl_seq_decode #(
        .PC_W        (PC_W),
        .LAST_ALU_OP (LAST_ALU_OP)
    ) u_decode (
        .ir         (ir_reg),
        .is_alu     (is_alu),
        .is_jmp     (is_jmp),
        .is_skc     (is_skc),
        .is_skz     (is_skz),
        .is_hlt     (is_hlt),
        .jmp_target (jmp_target)
    );

    assign fetch_word = instr_t'(imem_data);
    // Modulo 2^PC_W by construction of the width.
    assign pc_plus1   = pc + PC_W'(1);
    assign pc_plus2   = pc + PC_W'(2);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (run) state_next = ST_FETCH;
            ST_FETCH: begin
                if (imem_valid) state_next = ST_EXEC;
`ifdef CTRL_SEQ_TIMEOUT_EN
                else if (fetch_timeout) state_next = ST_HALT;
`endif
            end
            ST_EXEC: begin
                if (is_alu)      state_next = ST_WB;
                else if (is_hlt) state_next = ST_HALT;
                else             state_next = run ? ST_FETCH : ST_IDLE;
            end
            ST_WB:    state_next = run ? ST_FETCH : ST_IDLE;
            ST_HALT:  state_next = ST_HALT;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from state_next so they line up with the state
    // they describe; the async reset clears imem_req immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            pc        <= RESET_PC;
            ir_reg    <= '0;
            ans_q     <= '0;
            c_flag    <= 1'b0;
            z_flag    <= 1'b0;
            imem_req  <= 1'b0;
            alu_inst  <= '0;
            alu_b     <= '0;
            w_we      <= 1'b0;
            busy      <= 1'b0;
            halted    <= 1'b0;
        end else begin
            state_reg <= state_next;
            imem_req  <= (state_next == ST_FETCH);
            w_we      <= (state_next == ST_WB);
            busy      <= (state_next == ST_FETCH) || (state_next == ST_EXEC)
                         || (state_next == ST_WB);
            halted    <= (state_next == ST_HALT);

            // ALU controls appear in EXEC straight from the fetched word and
            // are held through WB (WB is only ever reached from an ALU EXEC).
            if (state_next == ST_EXEC && is_alu_op(fetch_word.op, LAST_ALU_OP)) begin
                alu_inst <= fetch_word.op;
                alu_b    <= fetch_word.lit;
            end else if (state_next != ST_WB) begin
                alu_inst <= '0;
                alu_b    <= '0;
            end

            case (state_reg)
                ST_FETCH: if (imem_valid) ir_reg <= fetch_word;
                ST_EXEC: begin
                    if (is_alu)      ans_q <= alu_ans;
                    else if (is_jmp) pc    <= jmp_target;
                    else if (is_skc) pc    <= c_flag ? pc_plus2 : pc_plus1;
                    else if (is_skz) pc    <= z_flag ? pc_plus2 : pc_plus1;
                    else if (!is_hlt) pc   <= pc_plus1;
                end
                ST_WB: begin
                    c_flag <= ans_q[8];
                    z_flag <= (ans_q[7:0] == 8'd0);
                    pc     <= pc_plus1;
                end
                default: ;
            endcase
        end
    end

`ifdef CTRL_SEQ_TIMEOUT_EN
    // Counter is zero whenever the sequencer enters FETCH because it is
    // cleared in every other state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_reg <= '0;
            imem_err     <= 1'b0;
        end else begin
            if (state_reg == ST_FETCH) wait_cnt_reg <= wait_cnt_reg + 4'd1;
            else                       wait_cnt_reg <= '0;
            if (fetch_timeout) imem_err <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/ctrl_seq.md
Name: ctrl_seq

Overview:
- Multi-cycle control sequencer for the 8-bit W-register/ALU datapath.
- Owns the program counter and fetches 16-bit instruction words from an instruction memory using a req/valid handshake.
- Decodes each word into ALU opcode and literal operand, then strobes the W-register write-back.
- Keeps carry/zero flags and handles jump, conditional-skip and halt instructions.

Parameters:
- PC_W, 17, program counter width.
- RESET_PC, 0, PC value loaded on reset.
- LAST_ALU_OP, 10, highest opcode forwarded to the ALU; opcodes 0..LAST_ALU_OP are ALU ops.
- TIMEOUT, 15, max wait cycles for imem_valid (optional feature only).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  level; sequencer leaves IDLE and keeps fetching while high.
- pc  out  PC_W  current instruction address.
- imem_req  out  1  fetch request.
- imem_valid  in  1  fetch data valid.
- imem_data  in  16  instruction word: [15:12] op, [11:8] hi, [7:0] lit.
- alu_inst  out  4  ALU opcode.
- alu_b  out  8  ALU b operand.
- alu_ans  in  9  ALU result; bit 8 is carry.
- w_we  out  1  W-register write strobe.
- c_flag  out  1  carry flag.
- z_flag  out  1  zero flag.
- busy  out  1  high in any state except IDLE/HALT.
- halted  out  1  high in HALT.

Behaviour:
- Reset (reset=0, async): state=IDLE, pc=RESET_PC, ir=0, c_flag=0, z_flag=0. All outputs 0 except pc.
- States: IDLE, FETCH, EXEC, WB, HALT.
- IDLE -> FETCH when run=1.
- FETCH:
  - imem_req=1 and pc held stable until imem_valid=1.
  - On that cycle ir<=imem_data; go to EXEC.
  - imem_valid while imem_req=0 is ignored.
- EXEC, one cycle:
  - ALU op (op<=LAST_ALU_OP): alu_inst=op, alu_b=lit. The ALU is combinational, so alu_ans is sampled at the end of this cycle into ans_q. Go to WB.
  - op 11 JMP: pc<={hi,lit} zero-extended to PC_W. Go to FETCH (or IDLE if run=0).
  - op 12 SKC: pc<=pc+2 if c_flag else pc+1.
  - op 13 SKZ: pc<=pc+2 if z_flag else pc+1.
  - op 14 NOP: pc<=pc+1.
  - op 15 HLT: go to HALT; pc unchanged.
- WB, one cycle:
  - w_we=1 with alu_inst and alu_b still held.
  - c_flag<=ans_q[8]; z_flag<=(ans_q[7:0]==0); pc<=pc+1.
  - Next state is FETCH if run=1, else IDLE.
- alu_inst/alu_b are 0 outside EXEC/WB.
- Latency with zero-wait memory (valid in the first FETCH cycle):
  - ALU op: 3 cycles.
  - JMP/SKC/SKZ/NOP: 2 cycles.
- pc arithmetic is modulo 2^PC_W; pc+1 and pc+2 wrap past 2^PC_W-1 to 0 or 1.
- run=0 is only sampled at instruction boundaries; an in-flight instruction always completes.
- HALT is left only via reset. run is ignored in HALT.
- Reset mid-FETCH drops imem_req in the same cycle. A late imem_valid after reset is ignored.
- Flags change only in WB; JMP/SKx/NOP/HLT leave them untouched.

Optional Feature:
- Macro: CTRL_SEQ_TIMEOUT_EN.
- Defined:
  - A 4-bit wait counter runs in FETCH, cleared on entry to FETCH.
  - If imem_valid is not seen within TIMEOUT cycles, go to HALT and set extra output port imem_err=1, sticky until reset.
- Undefined:
  - FETCH waits indefinitely.
  - No imem_err port and no counter logic.

Decomposition:
- Package ctrl_seq_pkg holds:
  - opcode constants OP_JMP=11, OP_SKC=12, OP_SKZ=13, OP_NOP=14, OP_HLT=15;
  - state enum state_t;
  - instruction field struct instr_t {op, hi, lit}.
- One sub-module, ctrl_seq_decode (combinational): from ir, produces is_alu, is_jmp, is_skc, is_skz, is_hlt and the jump target.
- Top holds the FSM, pc, ir, ans_q and flags.

Test Plan:
- Reset then run=1 with zero-wait memory, word 0x300A -> EXEC shows alu_inst=3, alu_b=10. Bench drives alu_ans=9'h10F -> WB shows w_we=1; then c_flag=1, z_flag=0, pc=1; 3 cycles total.
- pc=5, word 0xB123 -> pc=0x123 two cycles after valid; flags unchanged; no w_we.
- c_flag=1 at pc=7, SKC -> pc=9. With c_flag=0 -> pc=8. Same check for SKZ after alu_ans=9'h000 (z=1).
- imem_valid delayed 4 cycles -> imem_req stays high and pc stable for 4 cycles; instruction then executes normally. Deassert run during EXEC -> instruction completes, then IDLE with busy=0.
- pc=2^17-1, NOP -> pc=0. Word 0xF000 -> halted=1; run toggling has no effect; reset=0 clears to IDLE, pc=0.
- CTRL_SEQ_TIMEOUT_EN defined, imem_valid never asserted -> HALT and imem_err=1 after 15 FETCH cycles.
